count_interval_meter: RTL and testbench
=======================================

// Module: count_interval_meter
// PURPOSE
//   Receiving end of the loadable down-counter interface. It measures the cycles between a
//   load/start event and the matching terminal-count/stop event from that counter.
//   Each completed measurement goes into a one-entry result register read out via valid/ready.
//   Sits beside the down-counter in the count datapath; software or a checker reads the intervals.
// PARAMETERS
//   WIDTH     16   width of interval counter and result (matches 16-bit down-counter)
// PORTS
//   clk          in   1      rising-edge clock, sole clock
//   rst          in   1      synchronous, active-high reset
//   start_i      in   1      counter load pulse; begins a measurement
//   stop_i       in   1      counter terminal-count pulse; ends a measurement
//   res_ready_i  in   1      consumer accepts result when res_valid_o & res_ready_i
//   res_valid_o  out  1      result register holds an unread measurement
//   res_data_o   out  WIDTH  measured interval in cycles (saturated)
//   res_sat_o    out  1      result saturated at 2^WIDTH-1
//   busy_o       out  1      measurement in progress (state RUN)
//   overrun_o    out  1      sticky: a result was dropped because the register was full
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, cnt=0, sat=0.
//   All outputs 0: res_valid_o, res_data_o, res_sat_o, busy_o, overrun_o.
// - FSM, two states:
//   IDLE: stop_i ignored. start_i -> RUN with cnt=0, sat=0.
//   RUN: every cycle cnt <= cnt+1, saturating at 2^WIDTH-1. Reaching the maximum sets sat=1.
//     stop_i -> result R = sat-adjusted (cnt+1), S = sat | (cnt+1 overflowed).
//     Then -> IDLE, unless start_i is also high.
//     start_i without stop_i: restart. cnt=0, sat=0, no result, no flag.
//     start_i with stop_i: complete the current measurement and begin a new one.
//     State stays RUN, cnt=0, sat=0.
// - Interval definition: start at edge t, stop at edge t+N -> res_data_o=N (N>=1).
// - Result write, in the same cycle as the accepted stop:
//   - If the register is free (res_valid_o=0), or is being drained this cycle
//     (res_valid_o & res_ready_i): res_data_o<=R, res_sat_o<=S, res_valid_o<=1,
//     visible the next cycle.
//   - Otherwise R is dropped, overrun_o<=1, and the held result is unchanged.
// - Handshake: res_data_o and res_sat_o stay stable while res_valid_o=1 and ready=0.
//   Handshake with no new write: res_valid_o<=0. res_data_o and res_sat_o keep their last value.
// - busy_o = (state==RUN); registered, valid the cycle after start.
// - overrun_o clears only on rst.
// - Reset mid-measurement: the measurement is discarded, no result is produced, and the
//   held result is lost.
// - Arithmetic: unsigned WIDTH bits. Saturation never wraps to 0.
// TESTING
// 1. rst, start at cycle 10, stop at cycle 15, ready=1 -> res_valid_o=1 at cycle 16 for 1 cycle,
//    res_data_o=5, res_sat_o=0.
// 2. start, stop 1 cycle later -> res_data_o=1. stop in IDLE with no start -> no valid, busy_o=0.
// 3. start, stop 3 later with ready=0, then start, stop 7 later with ready=0 ->
//    res_data_o stays 3, overrun_o=1. ready=1 -> handshake, valid drops.
// 4. start and stop together in RUN after 4 cycles, stop 6 later ->
//    results 4 then 6, busy_o stays 1 between them.
// 5. WIDTH=4: start, stop 20 cycles later -> res_data_o=15, res_sat_o=1.
//    Next measurement of 2 -> res_sat_o=0.
// 6. start, rst asserted after 3 cycles, then stop -> no result; all outputs 0 after the reset edge.
//    start mid-RUN restart: start at 0, start at 5, stop at 8 -> res_data_o=3.

Source files
------------

// File: rtl/count_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : count_interval_meter
// Description : Measures the number of cycles between a load/start pulse and
//               the matching terminal-count/stop pulse of a down-counter.
//               Each completed interval is placed in a one-entry result
//               register that a consumer drains through valid/ready.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start_i, stop_i   - measurement start / stop pulses
//               res_ready_i       - consumer accepts the held result
//               res_valid_o       - result register holds an unread interval
//               res_data_o        - interval in cycles (saturating)
//               res_sat_o         - interval saturated at 2^WIDTH-1
//               busy_o            - a measurement is in progress
//               overrun_o         - sticky: a result was dropped (full)
// Revision    : 1.0 - initial release
// ============================================================================
module count_interval_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             res_ready_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_sat_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam logic [0:0]       S_IDLE = 1'b0;
    localparam logic [0:0]       S_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rsat_q, rsat_d;
    logic             ovr_q, ovr_d;

    // cnt holds (elapsed edges - 1), so the interval is cnt+1; the carry
    // flags that cnt+1 no longer fits.
    logic [WIDTH-1:0] cnt_inc;
    logic             cnt_carry;
    logic             done;
    logic [WIDTH-1:0] res_val;
    logic             res_flag;

    assign {cnt_carry, cnt_inc} = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    assign done     = (state_q == S_RUN) && stop_i;
    assign res_flag = sat_q | cnt_carry;
    assign res_val  = res_flag ? C_MAX : cnt_inc;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            rsat_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            rsat_q  <= rsat_d;
            ovr_q   <= ovr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (stop_i && !start_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter and result register update
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        data_d  = data_q;
        rsat_d  = rsat_q;
        ovr_d   = ovr_q;

        if (start_i || (state_q == S_IDLE) || stop_i) begin
            // A start (fresh or restart), an idle cycle or a finished
            // measurement all leave the counter cleared.
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (cnt_q == C_MAX) begin
            sat_d = 1'b1;
        end else begin
            cnt_d = cnt_inc;
            sat_d = sat_q | (cnt_inc == C_MAX);
        end

        if (done) begin
            // A result being drained this cycle frees the slot for the new one.
            if (!valid_q || res_ready_i) begin
                valid_d = 1'b1;
                data_d  = res_val;
                rsat_d  = res_flag;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && res_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign res_valid_o = valid_q;
    assign res_data_o  = data_q;
    assign res_sat_o   = rsat_q;
    assign busy_o      = (state_q == S_RUN);
    assign overrun_o   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_count_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_interval_meter
// Description : Self-checking bench for count_interval_meter. Two instances
//               (WIDTH=16 and WIDTH=4) share stimulus; a timestamp-based
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_interval_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic stop_i = 1'b0;
    logic ready_i = 1'b0;

    logic        v16, s16, b16, o16;
    logic [15:0] d16;
    logic        v4, s4, b4, o4;
    logic [3:0]  d4;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    count_interval_meter #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .res_ready_i(ready_i), .res_valid_o(v16), .res_data_o(d16),
        .res_sat_o(s16), .busy_o(b16), .overrun_o(o16)
    );

    count_interval_meter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .res_ready_i(ready_i), .res_valid_o(v4), .res_data_o(d4),
        .res_sat_o(s4), .busy_o(b4), .overrun_o(o4)
    );

    // ------------------------------------------------------------------
    // Reference model: remembers the cycle number of the start edge and
    // computes the interval as a plain difference, clamped to the maximum.
    // Index 0 models WIDTH=16, index 1 models WIDTH=4.
    // ------------------------------------------------------------------
    logic [63:0] cyc = 0;
    logic [63:0] m_st    [2];
    logic [63:0] m_data  [2];
    logic        m_run   [2];
    logic        m_valid [2];
    logic        m_sat   [2];
    logic        m_ovr   [2];
    logic [63:0] m_max   [2];
    logic [63:0] m_n;
    logic        m_done;

    initial begin
        m_max[0] = 64'd65535;
        m_max[1] = 64'd15;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_data[k] = 0; m_run[k] = 0;
            m_valid[k] = 0; m_sat[k] = 0; m_ovr[k] = 0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k] = 0; m_valid[k] = 0; m_data[k] = 0;
                m_sat[k] = 0; m_ovr[k] = 0;
            end else begin
                m_done = m_run[k] && stop_i;
                m_n    = cyc - m_st[k];
                if (m_done) begin
                    if (!m_valid[k] || ready_i) begin
                        m_valid[k] = 1;
                        m_data[k]  = (m_n > m_max[k]) ? m_max[k] : m_n;
                        m_sat[k]   = (m_n > m_max[k]);
                    end else begin
                        m_ovr[k] = 1;
                    end
                end else if (m_valid[k] && ready_i) begin
                    m_valid[k] = 0;
                end
                if (start_i) begin
                    m_run[k] = 1;
                    m_st[k]  = cyc;
                end else if (m_done) begin
                    m_run[k] = 0;
                end
            end
        end
    end

    logic [19:0] obs16, exp16;
    logic [7:0]  obs4, exp4;
    assign obs16 = {v16, d16, s16, b16, o16};
    assign exp16 = {m_valid[0], m_data[0][15:0], m_sat[0], m_run[0], m_ovr[0]};
    assign obs4  = {v4, d4, s4, b4, o4};
    assign exp4  = {m_valid[1], m_data[1][3:0], m_sat[1], m_run[1], m_ovr[1]};

    // Apply one cycle of inputs just after a falling edge, return at the next
    // falling edge so outputs are sampled away from the rising edge.
    task automatic drive(input logic s, input logic p, input logic r);
        start_i = s;
        stop_i  = p;
        ready_i = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            n_total++;
            if (obs16 !== 20'h0 || obs4 !== 8'h0) begin
                n_bad++;
                $display("FAIL reset_state got16=%h got4=%h exp=0", obs16, obs4);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (v16 !== 1'b1 || d16 !== 16'd5 || s16 !== 1'b0 || b16 !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_result got v=%b d=%0d s=%b b=%b exp v=1 d=5 s=0 b=0",
                     v16, d16, s16, b16);
        end
        drive(1'b0, 1'b0, 1'b1);
        n_total++;
        if (v16 !== 1'b0 || d16 !== 16'd5) begin
            n_bad++;
            $display("FAIL basic_one_cycle got v=%b d=%0d exp v=0 d=5", v16, d16);
        end
    endtask

    task automatic test_short_and_idle_stop();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_total++;
        if (v16 !== 1'b1 || d16 !== 16'd1) begin
            n_bad++;
            $display("FAIL interval_one got v=%b d=%0d exp v=1 d=1", v16, d16);
        end
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            n_total++;
            if (v16 !== 1'b0 || b16 !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_stop got v=%b busy=%b exp v=0 busy=0", v16, b16);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_total++;
        if (v16 !== 1'b1 || d16 !== 16'd3 || o16 !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun got v=%b d=%0d ovr=%b exp v=1 d=3 ovr=1", v16, d16, o16);
        end
        drive(1'b0, 1'b0, 1'b1);
        n_total++;
        if (v16 !== 1'b0 || d16 !== 16'd3 || o16 !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_drain got v=%b d=%0d ovr=%b exp v=0 d=3 ovr=1", v16, d16, o16);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        n_total++;
        if (v16 !== 1'b1 || d16 !== 16'd4 || b16 !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first got v=%b d=%0d busy=%b exp v=1 d=4 busy=1", v16, d16, b16);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            n_total++;
            if (b16 !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_busy got busy=%b exp busy=1", b16);
            end
        end
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (v16 !== 1'b1 || d16 !== 16'd6 || b16 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second got v=%b d=%0d busy=%b exp v=1 d=6 busy=0", v16, d16, b16);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (d4 !== 4'd15 || s4 !== 1'b1 || d16 !== 16'd20 || s16 !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_20 got d4=%0d s4=%b d16=%0d s16=%b exp 15 1 20 0", d4, s4, d16, s16);
        end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (v4 !== 1'b1 || d4 !== 4'd2 || s4 !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear got v=%b d4=%0d s4=%b exp v=1 d=2 s=0", v4, d4, s4);
        end
        // Exactly 2^WIDTH cycles is the first interval that does not fit.
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (d4 !== 4'd15 || s4 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_16 got d4=%0d s4=%b exp d=15 s=1", d4, s4);
        end
    endtask

    task automatic test_reset_mid_and_restart();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        n_total++;
        if (obs16 !== 20'h0 || obs4 !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_mid got16=%h got4=%h exp=0", obs16, obs4);
        end
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (v16 !== 1'b0 || b16 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_stop got v=%b busy=%b exp 0 0", v16, b16);
        end
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        n_total++;
        if (v16 !== 1'b0 || b16 !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_noresult got v=%b busy=%b exp v=0 busy=1", v16, b16);
        end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (v16 !== 1'b1 || d16 !== 16'd3) begin
            n_bad++;
            $display("FAIL restart got v=%b d=%0d exp v=1 d=3", v16, d16);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 200) == 0) rst = 1'b1;
            else rst = 1'b0;
            drive(($urandom % 12) == 0, ($urandom % 9) == 0, ($urandom % 3) != 0);
            n_total++;
            if (obs16 !== exp16 || obs4 !== exp4) begin
                n_bad++;
                $display("FAIL random cyc=%0d got16=%h exp16=%h got4=%h exp4=%h",
                         i, obs16, exp16, obs4, exp4);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_short_and_idle_stop();
        test_overrun();
        test_back_to_back();
        test_saturation();
        test_reset_mid_and_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
